// File: rtl/cmd_exec_pkg.sv
// Shared types and constants for the burst command executor: response packet
// layout, opcode/status encodings and the parser state set.
package cmd_exec_pkg;

    typedef struct packed {
        logic [7:0]  opcode;
        logic [7:0]  status;
        logic [31:0] addr;
        logic [31:0] data;
    } cmd_packet_t;

    localparam logic [7:0] OP_WRITE   = 8'h57;
    localparam logic [7:0] OP_READ    = 8'h52;

    localparam logic [7:0] ST_OK      = 8'h00;
    localparam logic [7:0] ST_BAD_OP  = 8'h01;
    localparam logic [7:0] ST_BAD_LEN = 8'h02;
    localparam logic [7:0] ST_TIMEOUT = 8'h03;

    typedef enum logic [2:0] {
        S_OPC,
        S_ADDR,
        S_LEN,
        S_WDATA,
        S_BUS,
        S_RESP,
        S_DRAIN
    } state_t;

    function automatic cmd_packet_t make_packet(input logic [7:0]  opcode,
                                                input logic [7:0]  status,
                                                input logic [31:0] addr,
                                                input logic [31:0] data);
        cmd_packet_t p;
        p.opcode = opcode;
        p.status = status;
        p.addr   = addr;
        p.data   = data;
        return p;
    endfunction

endpackage

// File: rtl/cmd_byte_assembler.sv
// Shifts W/8 bytes MSB-first into a W-bit field; done is raised combinationally
// alongside the shift of the final byte so the caller can move on at that edge.
module cmd_byte_assembler #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         shift_en,
    input  logic [7:0]   byte_in,
    output logic [W-1:0] value,
    output logic         done
);

    localparam int NB = W / 8;
    localparam int CW = (NB > 1) ? $clog2(NB) : 1;

    logic [CW-1:0] count;

    assign done = shift_en && (count == CW'(NB - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            value <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (shift_en) begin
            value <= W'({value, byte_in});
            count <= done ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/cmd_execute_burst.sv
// Parses burst read/write command frames from the RX byte FIFO, runs each word
// on the register bus with an ack timeout and pushes response packets.
module cmd_execute_burst
    import cmd_exec_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 16,
    parameter int TIMEOUT   = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              byte_fifo_valid,
    input  logic [7:0]        byte_fifo_data,
    output logic              byte_fifo_rd_en,
    output logic              reg_req,
    output logic              reg_we,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [DATA_W-1:0] reg_wdata,
    input  logic [DATA_W-1:0] reg_rdata,
    input  logic              reg_ack,
    output cmd_packet_t       cmd_resp_wr_data,
    output logic              cmd_resp_wr_en,
    input  logic              cmd_resp_full,
    output logic              busy
);

    localparam int          TW     = $clog2(TIMEOUT + 1);
    localparam logic [7:0]  MAX_N  = 8'(MAX_BURST);
    localparam logic [10:0] DBYTES = 11'(DATA_W / 8);

    state_t            state, next_state;
    logic [7:0]        opcode;
    logic [7:0]        count;
    logic [7:0]        words_left;
    logic [ADDR_W-1:0] addr_field, word_addr, start_addr;
    logic [DATA_W-1:0] data_field;
    logic [TW-1:0]     tcnt;
    logic [10:0]       drain_cnt;
    cmd_packet_t       resp_pkt;
    logic              addr_done, data_done;

    wire is_write  = (opcode == OP_WRITE);
    wire opc_ok    = (byte_fifo_data == OP_WRITE) || (byte_fifo_data == OP_READ);
    wire len_bad   = (byte_fifo_data == 8'd0) || (byte_fifo_data > MAX_N);
    wire timed_out = !reg_ack && (tcnt == TW'(TIMEOUT));

    cmd_byte_assembler #(.W(ADDR_W)) u_addr_asm (
        .clk      (clk),
        .rst      (rst),
        .clear    (state == S_OPC),
        .shift_en (byte_fifo_rd_en && state == S_ADDR),
        .byte_in  (byte_fifo_data),
        .value    (addr_field),
        .done     (addr_done)
    );

    cmd_byte_assembler #(.W(DATA_W)) u_data_asm (
        .clk      (clk),
        .rst      (rst),
        .clear    (state == S_OPC),
        .shift_en (byte_fifo_rd_en && state == S_WDATA),
        .byte_in  (byte_fifo_data),
        .value    (data_field),
        .done     (data_done)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= S_OPC;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_OPC:   if (byte_fifo_valid) next_state = opc_ok ? S_ADDR : S_RESP;
            S_ADDR:  if (addr_done) next_state = S_LEN;
            S_LEN:   if (byte_fifo_valid)
                         next_state = len_bad ? S_RESP : (is_write ? S_WDATA : S_BUS);
            S_WDATA: if (data_done) next_state = S_BUS;
            S_BUS: begin
                if (reg_ack)        next_state = (is_write && words_left > 8'd1) ? S_WDATA : S_RESP;
                else if (timed_out) next_state = S_RESP;
            end
            S_RESP: begin
                if (!cmd_resp_full) begin
                    if (!is_write && words_left != 8'd0) next_state = S_BUS;
                    else if (drain_cnt != 11'd0)         next_state = S_DRAIN;
                    else                                 next_state = S_OPC;
                end
            end
            S_DRAIN: if (byte_fifo_valid && drain_cnt == 11'd1) next_state = S_OPC;
            default: next_state = S_OPC;
        endcase
    end

    always_comb begin
        byte_fifo_rd_en = 1'b0;
        if (!rst && byte_fifo_valid &&
            (state == S_OPC || state == S_ADDR || state == S_LEN ||
             state == S_WDATA || state == S_DRAIN))
            byte_fifo_rd_en = 1'b1;
        reg_req        = (state == S_BUS);
        reg_we         = (state == S_BUS) && is_write;
        cmd_resp_wr_en = (state == S_RESP) && !cmd_resp_full;
        busy           = (state != S_OPC);
    end

    assign reg_addr         = word_addr;
    assign reg_wdata        = data_field;
    assign cmd_resp_wr_data = resp_pkt;

    // Timeout counter idles at zero outside BUS so every bus entry starts fresh.
    always_ff @(posedge clk) begin
        if (rst) begin
            opcode     <= '0;
            count      <= '0;
            words_left <= '0;
            word_addr  <= '0;
            start_addr <= '0;
            tcnt       <= '0;
            drain_cnt  <= '0;
            resp_pkt   <= '0;
        end else begin
            if (state != S_BUS) tcnt <= '0;
            case (state)
                S_OPC: if (byte_fifo_valid) begin
                    opcode     <= byte_fifo_data;
                    words_left <= '0;
                    drain_cnt  <= '0;
                    if (!opc_ok)
                        resp_pkt <= make_packet(byte_fifo_data, ST_BAD_OP, 32'h0, 32'h0);
                end
                S_LEN: if (byte_fifo_valid) begin
                    count      <= byte_fifo_data;
                    words_left <= len_bad ? 8'd0 : byte_fifo_data;
                    start_addr <= addr_field;
                    word_addr  <= addr_field;
                    if (len_bad)
                        resp_pkt <= make_packet(opcode, ST_BAD_LEN, 32'(addr_field),
                                                32'(byte_fifo_data));
                end
                S_BUS: begin
                    if (reg_ack) begin
                        words_left <= words_left - 8'd1;
                        word_addr  <= word_addr + 1'b1;
                        if (!is_write)
                            resp_pkt <= make_packet(opcode, ST_OK, 32'(word_addr), 32'(reg_rdata));
                        else if (words_left == 8'd1)
                            resp_pkt <= make_packet(opcode, ST_OK, 32'(start_addr), 32'(count));
                    end else if (timed_out) begin
                        resp_pkt   <= make_packet(opcode, ST_TIMEOUT, 32'(word_addr), 32'h0);
                        words_left <= '0;
                        if (is_write)
                            drain_cnt <= 11'(({3'b000, words_left} - 11'd1) * DBYTES);
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                S_DRAIN: if (byte_fifo_valid) drain_cnt <= drain_cnt - 11'd1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cmd_execute_burst.sv
// Randomised scoreboard bench for cmd_execute_burst with ADDR_W=16, DATA_W=32:
// a frame-level model predicts bus operations and response packets.
module tb_cmd_execute_burst;
    import cmd_exec_pkg::*;

    localparam int ADDR_W    = 16;
    localparam int DATA_W    = 32;
    localparam int MAX_BURST = 16;
    localparam int TIMEOUT   = 10;

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [31:0] wdata;
        int          delay;
    } bus_exp_t;

    typedef struct {
        cmd_packet_t pkt;
        bit          full_chk;
    } resp_exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              byte_fifo_valid;
    logic [7:0]        byte_fifo_data;
    logic              byte_fifo_rd_en;
    logic              reg_req, reg_we;
    logic [ADDR_W-1:0] reg_addr;
    logic [DATA_W-1:0] reg_wdata, reg_rdata;
    logic              reg_ack;
    cmd_packet_t       cmd_resp_wr_data;
    logic              cmd_resp_wr_en, cmd_resp_full, busy;

    logic [7:0] rx_q[$];
    bus_exp_t   bus_q[$];
    resp_exp_t  sb_q[$];
    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    int         last_ack_cyc = -100;
    bit         rand_full_en = 0;
    bit         full_force = 0;
    bit         latency_chk_en = 1;

    cmd_execute_burst #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .byte_fifo_valid  (byte_fifo_valid),
        .byte_fifo_data   (byte_fifo_data),
        .byte_fifo_rd_en  (byte_fifo_rd_en),
        .reg_req          (reg_req),
        .reg_we           (reg_we),
        .reg_addr         (reg_addr),
        .reg_wdata        (reg_wdata),
        .reg_rdata        (reg_rdata),
        .reg_ack          (reg_ack),
        .cmd_resp_wr_data (cmd_resp_wr_data),
        .cmd_resp_wr_en   (cmd_resp_wr_en),
        .cmd_resp_full    (cmd_resp_full),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    function automatic logic [31:0] rdata_of(input logic [15:0] a);
        return 32'(a) + 32'h100;
    endfunction

    task automatic checkOutput(input string name, input logic [79:0] actual,
                               input logic [79:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)",
                     name, actual, expected, cyc);
        end
    endtask

    // Frame-level model: bytes go to the RX queue, predictions to the scoreboards.
    task automatic applyStimulus(input logic [7:0] op, input logic [15:0] addr,
                                 input int n, input int fail_word,
                                 input int dmin, input int dmax,
                                 input logic [31:0] first_word);
        logic [7:0]  frame[$];
        logic [31:0] wd[$];
        bus_exp_t    b;
        resp_exp_t   r;
        bit          failed = 0;
        frame.push_back(op);
        if (op != OP_WRITE && op != OP_READ) begin
            r.pkt = '{op, ST_BAD_OP, 32'h0, 32'h0};
            r.full_chk = 1;
            sb_q.push_back(r);
        end else begin
            frame.push_back(addr[15:8]);
            frame.push_back(addr[7:0]);
            frame.push_back(8'(n));
            if (n < 1 || n > MAX_BURST) begin
                r.pkt = '{op, ST_BAD_LEN, 32'h0, 32'h0};
                r.full_chk = 0;
                sb_q.push_back(r);
            end else begin
                for (int i = 0; i < n; i++) begin
                    wd.push_back((i == 0) ? first_word : $urandom);
                    if (op == OP_WRITE)
                        for (int k = 3; k >= 0; k--) frame.push_back(wd[i][8*k +: 8]);
                end
                for (int i = 0; i < n; i++) begin
                    b.we    = (op == OP_WRITE);
                    b.addr  = addr + 16'(i);
                    b.wdata = wd[i];
                    b.delay = (i == fail_word) ? -1 : int'($urandom_range(dmax, dmin));
                    bus_q.push_back(b);
                    r.full_chk = 1;
                    if (b.delay < 0) begin
                        r.pkt = '{op, ST_TIMEOUT, 32'(b.addr), 32'h0};
                        sb_q.push_back(r);
                        failed = 1;
                        break;
                    end
                    if (op == OP_READ) begin
                        r.pkt = '{op, ST_OK, 32'(b.addr), rdata_of(b.addr)};
                        sb_q.push_back(r);
                    end
                end
                if (op == OP_WRITE && !failed) begin
                    r.pkt = '{op, ST_OK, 32'(addr), 32'(n)};
                    r.full_chk = 1;
                    sb_q.push_back(r);
                end
            end
        end
        foreach (frame[i]) rx_q.push_back(frame[i]);
    endtask

    task automatic waitIdle(input int budget);
        int k = 0;
        while (!(rx_q.size() == 0 && sb_q.size() == 0 && bus_q.size() == 0 && !busy)
               && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (k >= budget) begin
            checks++;
            failures++;
            $display("[TB] FAIL idle_wait: actual rx=%0d resp=%0d bus=%0d busy=%0b required all empty",
                     rx_q.size(), sb_q.size(), bus_q.size(), busy);
            rx_q.delete();
            sb_q.delete();
            bus_q.delete();
        end
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_busy"}, busy, 1'b0);
        checkOutput({tag, "_reg_req"}, reg_req, 1'b0);
        checkOutput({tag, "_reg_we"}, reg_we, 1'b0);
        checkOutput({tag, "_wr_en"}, cmd_resp_wr_en, 1'b0);
        checkOutput({tag, "_rd_en"}, byte_fifo_rd_en, 1'b0);
        checkOutput({tag, "_reg_addr"}, reg_addr, 16'h0);
        checkOutput({tag, "_reg_wdata"}, reg_wdata, 32'h0);
        checkOutput({tag, "_resp_data"}, cmd_resp_wr_data, 80'h0);
    endtask

    // RX FIFO model: first-word-fall-through with random empty gaps.
    initial begin
        bit pop_seen;
        byte_fifo_valid = 1'b0;
        byte_fifo_data  = 8'h0;
        forever begin
            @(negedge clk);
            pop_seen = byte_fifo_rd_en;
            @(posedge clk);
            if (pop_seen && rx_q.size() > 0) void'(rx_q.pop_front());
            #1;
            if (rx_q.size() > 0 && $urandom_range(4) != 0) begin
                byte_fifo_valid = 1'b1;
                byte_fifo_data  = rx_q[0];
            end else begin
                byte_fifo_valid = 1'b0;
                byte_fifo_data  = 8'($urandom);
            end
        end
    end

    initial begin
        cmd_resp_full = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cmd_resp_full = rand_full_en ? ($urandom_range(3) == 0) : full_force;
        end
    end

    // Register bus slave: checks each request against the predicted operation.
    initial begin
        bus_exp_t cur;
        bit       serving = 0;
        bit       have_exp = 0;
        int       req_cycles = 0;
        reg_ack   = 1'b0;
        reg_rdata = '0;
        forever begin
            @(negedge clk);
            reg_ack   = 1'b0;
            reg_rdata = $urandom;
            if (reg_req) begin
                if (!serving) begin
                    serving    = 1;
                    req_cycles = 0;
                    have_exp   = (bus_q.size() != 0);
                    if (have_exp) cur = bus_q.pop_front();
                    else begin
                        checks++;
                        failures++;
                        $display("[TB] FAIL bus_unexpected: actual req addr=0x%0h required no request",
                                 reg_addr);
                    end
                end
                req_cycles++;
                if (have_exp) begin
                    checkOutput("bus_we", reg_we, cur.we);
                    checkOutput("bus_addr", reg_addr, cur.addr);
                    if (cur.we) checkOutput("bus_wdata", reg_wdata, cur.wdata);
                    if (cur.delay >= 0 && req_cycles == cur.delay + 1) begin
                        reg_ack      = 1'b1;
                        reg_rdata    = rdata_of(cur.addr);
                        last_ack_cyc = cyc;
                    end
                end
            end else if (serving) begin
                serving = 0;
                if (have_exp && cur.delay < 0)
                    checkOutput("timeout_req_cycles", req_cycles, TIMEOUT + 1);
            end
        end
    end

    // Response monitor: pops the scoreboard on every push.
    initial begin
        resp_exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && cmd_resp_wr_en) begin
                checkOutput("push_while_full", cmd_resp_full, 1'b0);
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL resp_unexpected: actual packet=0x%0h required none",
                             cmd_resp_wr_data);
                end else begin
                    e = sb_q.pop_front();
                    if (e.full_chk)
                        checkOutput("resp_packet", cmd_resp_wr_data, e.pkt);
                    else
                        checkOutput("resp_op_status",
                                    {cmd_resp_wr_data.opcode, cmd_resp_wr_data.status},
                                    {e.pkt.opcode, e.pkt.status});
                    if (latency_chk_en && e.pkt.opcode == OP_READ && e.pkt.status == ST_OK)
                        checkOutput("read_latency", cyc - last_ack_cyc, 1);
                end
            end
        end
    end

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: actual=still running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int push_cnt, req_cnt, k;
        logic [7:0] op;
        int n, fw, r;

        repeat (3) @(negedge clk);
        checkReset("por");
        rst = 1'b0;
        @(negedge clk);
        checkOutput("idle_busy", busy, 1'b0);

        $display("[TB] directed frames");
        applyStimulus(OP_WRITE, 16'h1234, 1, -1, 3, 3, 32'hDEADBEEF);
        applyStimulus(OP_READ,  16'h12FE, 3, -1, 0, 0, 32'h0);
        applyStimulus(OP_READ,  16'hFFFF, 2, -1, 0, 2, 32'h0);
        applyStimulus(8'h41,    16'h0000, 0, -1, 0, 0, 32'h0);
        applyStimulus(OP_WRITE, 16'h00A0, 2, -1, 0, 2, 32'h01234567);
        applyStimulus(OP_READ,  16'h0050, 0, -1, 0, 0, 32'h0);
        applyStimulus(OP_WRITE, 16'h0060, MAX_BURST + 1, -1, 0, 0, 32'h0);
        applyStimulus(OP_READ,  16'h0700, MAX_BURST, -1, 0, 1, 32'h0);
        applyStimulus(OP_WRITE, 16'h0200, 2, 0, 0, 0, 32'h11112222);
        applyStimulus(OP_READ,  16'h0300, 3, 1, 0, 0, 32'h0);
        applyStimulus(OP_WRITE, 16'h0210, 1, -1, 1, 1, 32'hCAFEF00D);
        waitIdle(5000);

        $display("[TB] random frames with response backpressure");
        rand_full_en   = 1;
        latency_chk_en = 0;
        for (int i = 0; i < 30; i++) begin
            r  = $urandom_range(99);
            op = (r < 8) ? 8'($urandom) : ((r < 54) ? OP_WRITE : OP_READ);
            if (op == OP_WRITE && r < 8) op = 8'h00;
            if (op == OP_READ && r < 8)  op = 8'hFF;
            n  = $urandom_range(4, 1);
            fw = ($urandom_range(9) == 0) ? int'($urandom_range(n - 1)) : -1;
            applyStimulus(op, 16'($urandom), n, fw, 0, 3, $urandom);
        end
        waitIdle(20000);
        rand_full_en = 0;

        $display("[TB] response FIFO held full during a read burst");
        full_force = 1;
        repeat (2) @(negedge clk);
        applyStimulus(OP_READ, 16'h0400, 2, -1, 0, 0, 32'h0);
        k = 0;
        while (rx_q.size() != 0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        push_cnt = 0;
        req_cnt  = 0;
        for (int i = 0; i < 20; i++) begin
            push_cnt += int'(cmd_resp_wr_en);
            req_cnt  += int'(reg_req);
            @(negedge clk);
        end
        checkOutput("full_no_push", push_cnt, 0);
        checkOutput("full_req_cycles", req_cnt, 1);
        checkOutput("full_busy", busy, 1'b1);
        if (sb_q.size() != 0)
            checkOutput("full_pkt_stable", cmd_resp_wr_data, sb_q[0].pkt);
        full_force = 0;
        waitIdle(2000);
        latency_chk_en = 1;

        $display("[TB] reset in the middle of a write payload");
        rx_q.push_back(OP_WRITE);
        rx_q.push_back(8'h00);
        rx_q.push_back(8'h10);
        rx_q.push_back(8'h02);
        rx_q.push_back(8'hAA);
        rx_q.push_back(8'hBB);
        rx_q.push_back(8'hCC);
        k = 0;
        while (rx_q.size() != 0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        checkOutput("mid_wdata_busy", busy, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        checkReset("mid_rst");
        rst = 1'b0;
        applyStimulus(OP_WRITE, 16'h0BEE, 2, -1, 0, 2, 32'h5A5AA5A5);
        applyStimulus(OP_READ,  16'h0BEE, 2, -1, 0, 2, 32'h0);
        waitIdle(3000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cmd_execute_burst.md
Name: cmd_execute_burst

Overview:
Parametrised successor to the single-byte command executor. Consumes the UART RX byte FIFO and parses read/write commands with multi-byte address and data fields and bursts of 1..MAX_BURST words. Executes each word on a register bus with ack and timeout. Pushes cmd_packet_t responses into the TX response FIFO, with full-flag backpressure.

Parameters:
ADDR_W, 8, register address width in bits; multiple of 8, 8..32
DATA_W, 8, register data width in bits; multiple of 8, 8..32
MAX_BURST, 16, maximum words per command; 1..255
TIMEOUT, 255, cycles to wait for reg_ack before aborting; >=1

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
byte_fifo_valid  in  1  RX FIFO non-empty (first-word-fall-through)
byte_fifo_data  in  8  RX FIFO head byte
byte_fifo_rd_en  out  1  pop RX FIFO head this cycle
reg_req  out  1  bus request; held until reg_ack or timeout
reg_we  out  1  1 = write, 0 = read; valid with reg_req
reg_addr  out  ADDR_W  bus address
reg_wdata  out  DATA_W  write data
reg_rdata  in  DATA_W  read data; valid when reg_ack=1
reg_ack  in  1  single-cycle completion
cmd_resp_wr_data  out  cmd_packet_t  response packet
cmd_resp_wr_en  out  1  push response; one-cycle pulse
cmd_resp_full  in  1  response FIFO full
busy  out  1  high in any state other than OPC

Behaviour:
- Reset (synchronous; any state, mid-burst included): state=OPC. reg_req, reg_we, cmd_resp_wr_en and byte_fifo_rd_en are 0 from the next cycle. reg_addr, reg_wdata and cmd_resp_wr_data are 0. Counters are cleared. A partial command is discarded.
- byte_fifo_rd_en = byte_fifo_valid while in a byte-consuming state (OPC, ADDR, LEN, WDATA, DRAIN). The byte is captured on the same edge it is popped. A stalled FIFO just holds the state.
- Frame format: opcode byte, then ADDR_W/8 address bytes (MSB first), then a count byte N, then for writes N×DATA_W/8 data bytes (MSB first, word by word).
- Opcodes: 0x57 = write, 0x52 = read.
- Any other opcode goes to RESP with status 0x01 (opcode = byte received, addr = 0, data = 0). Only that one byte is consumed.
- OPC -> ADDR -> LEN.
- At LEN: N=0 or N>MAX_BURST -> RESP with status 0x02. Write payload bytes are NOT drained; they are reparsed as opcodes. Otherwise:
  - write -> WDATA
  - read -> BUS
- WDATA: after DATA_W/8 bytes the word is assembled -> BUS.
- BUS: reg_req=1 with reg_we, reg_addr and reg_wdata stable until reg_ack.
  - The timeout counter starts at 0 on BUS entry and increments every cycle without ack.
  - Ack arriving in the same cycle the counter reaches TIMEOUT counts as success.
  - reg_req drops the cycle after ack.
- Read ack: capture reg_rdata -> RESP (status 0x00, addr = word address, data = rdata), one packet per word.
- Write ack: if more words remain -> WDATA, else RESP (status 0x00, addr = start address, data = N zero-extended), one packet per command.
- Address increments by 1 per word and wraps modulo 2^ADDR_W.
- Timeout: reg_req drops and RESP gets status 0x03 with the failing address.
  - For a write, the remaining payload bytes are then drained in DRAIN, then -> OPC.
  - For a read, the remaining words are abandoned.
- RESP: cmd_resp_wr_en pulses for one cycle on the first cycle with cmd_resp_full=0. The packet is stable while waiting.
  - After the push: if read words remain -> BUS; else if drain is pending -> DRAIN; else -> OPC.
- Latency: a read word's response is pushed 1 cycle after reg_ack when the response FIFO is not full.
- The next opcode byte is popped no earlier than the cycle after the final response push.

Decomposition:
- Package cmd_exec_pkg holds:
  - cmd_packet_t (packed: opcode[7:0], status[7:0], addr[31:0], data[31:0]; narrower fields zero-extended)
  - opcode constants OP_WRITE and OP_READ
  - status constants ST_OK, ST_BAD_OP, ST_BAD_LEN, ST_TIMEOUT
  - state enum
- Sub-module cmd_byte_assembler: shifts N bytes MSB-first into a width-parametrised register and reports done. It is reused for the address and data fields.

Test Plan:
- ADDR_W=16, DATA_W=32: write frame 57 12 34 01 DE AD BE EF, ack after 3 cycles -> one bus write addr=0x1234, wdata=0xDEADBEEF; one response {57, 00, 1234, 1}.
- Read burst 52 12 FE 03 with rdata = addr+0x100, ADDR_W=16 -> bus reads at 0x12FE, 0x12FF, 0x1300; three responses in order.
- ADDR_W=8 read 52 FF 02 -> addresses 0xFF then 0x00 (wrap).
- Opcode 0x41 -> response {41, 01, 0, 0}; next frame parses normally. Count 0x00 -> status 0x02.
- Write of 2 words with no reg_ack, TIMEOUT=10 -> reg_req drops after 11 request cycles; status 0x03 response; remaining 4 payload bytes drained; next command executes correctly.
- cmd_resp_full held high 20 cycles during a read burst -> no wr_en, packet stable, no further bus request. rst asserted mid-WDATA -> idle next cycle, fresh frame succeeds.
